// File: rtl/core_pkg.sv
// core_pkg: shared ROB tag and register width constants and types for the rename register file.
package core_pkg;
  localparam int ROB_W = 4;
  localparam int XLEN = 32;
  typedef logic [ROB_W-1:0] rob_tag_t;
  typedef logic [XLEN-1:0] xlen_t;
  localparam rob_tag_t NO_TAG = '0;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/rename_regfile.sv
// rename_regfile: 32-entry architectural register file with ROB rename tags and commit bypass.
// Optional REGFILE_FLUSH_EN adds flush_in, which clears every tag on misprediction recovery.
module rename_regfile
  import core_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
`ifdef REGFILE_FLUSH_EN
  input  logic       flush_in,
`endif
  input  logic       query,
  input  logic [4:0] query_index,
  input  logic       reorder,
  input  rob_tag_t   reorder_entry,
  input  logic [4:0] reorder_rd,
  input  logic       modify,
  input  rob_tag_t   modify_entry,
  input  logic [4:0] modify_index,
  input  xlen_t      modify_value,
  output rob_tag_t   query_entry,
  output xlen_t      query_value
);
  xlen_t    val_q [32];
  xlen_t    val_d [32];
  rob_tag_t tag_q [32];
  rob_tag_t tag_d [32];
  logic     hit, byp;
  always_comb begin
    val_d = val_q;
    tag_d = tag_q;
    if (modify && modify_index != REG_ZERO) begin
      val_d[modify_index] = modify_value;
      if (tag_q[modify_index] == modify_entry) tag_d[modify_index] = NO_TAG;
    end
`ifdef REGFILE_FLUSH_EN
    if (flush_in) tag_d = '{default: NO_TAG};
    else if (reorder && reorder_rd != REG_ZERO) tag_d[reorder_rd] = reorder_entry;
`else
    if (reorder && reorder_rd != REG_ZERO) tag_d[reorder_rd] = reorder_entry;
`endif
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      val_q <= '{default: '0};
      tag_q <= '{default: NO_TAG};
    end else if (rdy_in) begin
      val_q <= val_d;
      tag_q <= tag_d;
    end
  end
  // A matching commit is visible to readers in the cycle it retires, against the pre-edge tag.
  always_comb begin
    hit = query && query_index != REG_ZERO;
    byp = hit && modify && modify_index == query_index && tag_q[query_index] == modify_entry;
    query_entry = (hit && !byp) ? tag_q[query_index] : NO_TAG;
    query_value = byp ? modify_value : hit ? val_q[query_index] : '0;
  end
endmodule

// File: tb/tb_rename_regfile.sv
// tb_rename_regfile: directed self-checking bench for rename_regfile.
module tb_rename_regfile;
  import core_pkg::*;
  logic       clk_in = 0, rst_in = 0, rdy_in = 1;
  logic       flush_in = 0;
  logic       query = 0, reorder = 0, modify = 0;
  logic [4:0] query_index = 0, reorder_rd = 0, modify_index = 0;
  rob_tag_t   reorder_entry = 0, modify_entry = 0, query_entry;
  xlen_t      modify_value = 0, query_value;
  int         checks = 0, errors = 0;
  always #5 clk_in = ~clk_in;
  rename_regfile dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
`ifdef REGFILE_FLUSH_EN
    .flush_in(flush_in),
`endif
    .query(query), .query_index(query_index),
    .reorder(reorder), .reorder_entry(reorder_entry), .reorder_rd(reorder_rd),
    .modify(modify), .modify_entry(modify_entry), .modify_index(modify_index),
    .modify_value(modify_value),
    .query_entry(query_entry), .query_value(query_value)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic rd(input string tag, input logic [4:0] idx, input rob_tag_t e, input xlen_t v);
    query = 1;
    query_index = idx;
    #1;
    chk({tag, ".entry"}, 32'(query_entry), 32'(e));
    chk({tag, ".value"}, query_value, v);
  endtask
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask
  task automatic idle();
    reorder = 0;
    modify = 0;
    flush_in = 0;
  endtask
  task automatic ren(input logic [4:0] r, input rob_tag_t e);
    reorder = 1; reorder_rd = r; reorder_entry = e;
  endtask
  task automatic com(input logic [4:0] r, input rob_tag_t e, input xlen_t v);
    modify = 1; modify_index = r; modify_entry = e; modify_value = v;
  endtask
  initial begin
    #2;
    rd("rst0", 5'd5, 0, 0);
    rst_in = 1;
    step();
    com(5, 0, 32'h1234);
    step();
    idle();
    rd("x5_written", 5'd5, 0, 32'h1234);
    rst_in = 0;
    rd("async_rst", 5'd5, 0, 0);
    step();
    rst_in = 1;
    step();
    ren(3, 7);
    step();
    idle();
    rd("rename_x3", 5'd3, 7, 0);
    com(3, 7, 32'hDEADBEEF);
    rd("bypass_x3", 5'd3, 0, 32'hDEADBEEF);
    step();
    idle();
    rd("commit_x3", 5'd3, 0, 32'hDEADBEEF);
    ren(4, 2);
    step();
    ren(4, 9);
    step();
    idle();
    com(4, 2, 32'h55);
    rd("stale_nobyp", 5'd4, 9, 0);
    step();
    idle();
    rd("stale_x4", 5'd4, 9, 32'h55);
    ren(0, 5);
    com(0, 0, 32'hFF);
    rd("x0_same", 5'd0, 0, 0);
    step();
    idle();
    rd("x0_after", 5'd0, 0, 0);
    rdy_in = 0;
    ren(6, 3);
    step();
    idle();
    rdy_in = 1;
    rd("stall_x6", 5'd6, 0, 0);
    rdy_in = 0;
    com(7, 0, 32'hAB);
    rd("stall_byp", 5'd7, 0, 32'hAB);
    step();
    idle();
    rdy_in = 1;
    rd("stall_x7", 5'd7, 0, 0);
    ren(8, 4);
    com(8, 0, 32'h10);
    step();
    idle();
    rd("conflict_x8", 5'd8, 4, 32'h10);
    query = 0;
    #1;
    chk("qoff.entry", 32'(query_entry), 0);
    chk("qoff.value", query_value, 0);
`ifdef REGFILE_FLUSH_EN
    flush_in = 1;
    ren(9, 6);
    step();
    idle();
    rd("flush_x8", 5'd8, 0, 32'h10);
    rd("flush_x9", 5'd9, 0, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
